// File: rtl/psx_pad_decoder_pkg.sv
// Shared constants for the PSX controller poll-frame decoder: wire bytes, error codes,
// FSM encodings and the ID acceptance rule.
package psx_pad_decoder_pkg;

   localparam logic [7:0] PSX_HDR_5A     = 8'h5A;
   localparam logic [7:0] PSX_ID_DIGITAL = 8'h41;
   localparam logic [7:0] PSX_ID_ANALOG  = 8'h73;
   localparam logic [7:0] PSX_ID_NONE    = 8'hFF;
   localparam logic [7:0] JOY_CENTER     = 8'h80;

   localparam logic [1:0] ERR_HDR     = 2'd0;
   localparam logic [1:0] ERR_ID      = 2'd1;
   localparam logic [1:0] ERR_SHORT   = 2'd2;
   localparam logic [1:0] ERR_OVERRUN = 2'd3;

   localparam logic [2:0] ST_SYNC  = 3'd0;
   localparam logic [2:0] ST_IDLE  = 3'd1;
   localparam logic [2:0] ST_HDR0  = 3'd2;
   localparam logic [2:0] ST_ID    = 3'd3;
   localparam logic [2:0] ST_HDR5A = 3'd4;
   localparam logic [2:0] ST_DATA  = 3'd5;
   localparam logic [2:0] ST_TAIL  = 3'd6;
   localparam logic [2:0] ST_ERRW  = 3'd7;

   // Low nibble of the ID is the payload length in 16-bit halfwords.
   function automatic logic id_ok(input logic [7:0] id, input int unsigned max_bytes);
      return (id[3:0] != 4'd0) && (id != PSX_ID_NONE) && ({27'd0, id[3:0], 1'b0} <= max_bytes);
   endfunction

endpackage

// File: rtl/psx_pad_decoder_if.sv
// Byte-stream input and decoded pad state of the PSX poll-frame decoder.
// master = host shifter / consumer side, slave = decoder.
interface psx_pad_decoder_if;

   logic        att;
   logic        rx_valid;
   logic [7:0]  rx_byte;
   logic [15:0] buttons;
   logic [7:0]  rjoy_x;
   logic [7:0]  rjoy_y;
   logic [7:0]  ljoy_x;
   logic [7:0]  ljoy_y;
   logic [7:0]  pad_id;
   logic        frame_done;
   logic        frame_err;
   logic [1:0]  err_code;
   logic        connected;

   modport master (
      output att, rx_valid, rx_byte,
      input  buttons, rjoy_x, rjoy_y, ljoy_x, ljoy_y, pad_id,
      input  frame_done, frame_err, err_code, connected
   );

   modport slave (
      input  att, rx_valid, rx_byte,
      output buttons, rjoy_x, rjoy_y, ljoy_x, ljoy_y, pad_id,
      output frame_done, frame_err, err_code, connected
   );

endinterface

// File: rtl/psx_pad_decoder_edge_det.sv
// Registers the active-low attention line once and derives frame start (fall)
// and frame end (rise) pulses.
module psx_pad_decoder_edge_det (
   input  logic clk,
   input  logic rst,
   input  logic att,
   output logic start,
   output logic stop
);

   logic att_q;

   always_ff @(posedge clk) begin
      if (rst) att_q <= 1'b1;
      else     att_q <= att;
   end

   assign start = att_q & ~att;
   assign stop  = ~att_q & att;

endmodule

// File: rtl/psx_pad_decoder.sv
// Parses one PSX controller poll frame per attention-low window, commits button and
// analog state atomically on frame end, and flags malformed or absent-pad frames.
module psx_pad_decoder #(
   parameter int unsigned MAX_DATA_BYTES = 6,
   parameter int unsigned MISS_LIMIT     = 3
) (
   input logic              clk,
   input logic              rst,
   psx_pad_decoder_if.slave bus
);

   import psx_pad_decoder_pkg::*;

   localparam int unsigned IDX_W     = $clog2(MAX_DATA_BYTES + 1);
   localparam int unsigned MISS_W    = $clog2(MISS_LIMIT + 1);
   localparam int unsigned JOY_BYTES = 6;

   logic             start, stop;
   logic [2:0]       state_q, state_d, st_byte;
   logic [IDX_W-1:0] idx_q, idx_d, len_q, len_d;
   logic [7:0]       id_q, id_d;
   logic [7:0]       shadow_q [MAX_DATA_BYTES];
   logic             shadow_we;
   logic             commit_q, commit_d, short_q, short_d;
   logic             err_now, err_fire;
   logic [1:0]       err_now_code, err_fire_code;

   logic [15:0]      buttons_q;
   logic [7:0]       rjoy_x_q, rjoy_y_q, ljoy_x_q, ljoy_y_q, pad_id_q;
   logic             frame_done_q, frame_err_q, connected_q;
   logic [1:0]       err_code_q;
   logic [MISS_W-1:0] miss_q;

   psx_pad_decoder_edge_det u_edge_det (
      .clk   (clk),
      .rst   (rst),
      .att   (bus.att),
      .start (start),
      .stop  (stop)
   );

   always_comb begin
      st_byte      = state_q;
      idx_d        = idx_q;
      len_d        = len_q;
      id_d         = id_q;
      shadow_we    = 1'b0;
      err_now      = 1'b0;
      err_now_code = ERR_HDR;
      commit_d     = 1'b0;
      short_d      = 1'b0;

      // Byte handling first; the end edge is then judged against the post-byte state.
      case (state_q)
         ST_SYNC: if (bus.att) st_byte = ST_IDLE;
         ST_IDLE: if (start) begin
            st_byte = ST_HDR0;
            idx_d   = '0;
         end
         ST_HDR0: if (bus.rx_valid) st_byte = ST_ID;
         ST_ID: if (bus.rx_valid) begin
            if (id_ok(bus.rx_byte, MAX_DATA_BYTES)) begin
               len_d   = IDX_W'({bus.rx_byte[3:0], 1'b0});
               id_d    = bus.rx_byte;
               st_byte = ST_HDR5A;
            end else begin
               err_now      = 1'b1;
               err_now_code = ERR_ID;
               st_byte      = ST_ERRW;
            end
         end
         ST_HDR5A: if (bus.rx_valid) begin
            if (bus.rx_byte == PSX_HDR_5A) begin
               st_byte = ST_DATA;
            end else begin
               err_now      = 1'b1;
               err_now_code = ERR_HDR;
               st_byte      = ST_ERRW;
            end
         end
         ST_DATA: if (bus.rx_valid) begin
            shadow_we = 1'b1;
            if (idx_q == len_q - IDX_W'(1)) st_byte = ST_TAIL;
            else                             idx_d   = idx_q + IDX_W'(1);
         end
         ST_TAIL: if (bus.rx_valid) begin
            err_now      = 1'b1;
            err_now_code = ERR_OVERRUN;
            st_byte      = ST_ERRW;
         end
         default: ;
      endcase

      state_d = st_byte;
      if (stop) begin
         case (st_byte)
            ST_HDR0, ST_ID, ST_HDR5A, ST_DATA: begin
               short_d = 1'b1;
               state_d = ST_IDLE;
            end
            ST_TAIL: begin
               commit_d = 1'b1;
               state_d  = ST_IDLE;
            end
            ST_ERRW: state_d = ST_IDLE;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_SYNC;
         idx_q    <= '0;
         len_q    <= '0;
         id_q     <= PSX_ID_NONE;
         commit_q <= 1'b0;
         short_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         len_q    <= len_d;
         id_q     <= id_d;
         commit_q <= commit_d;
         short_q  <= short_d;
      end
   end

   always_ff @(posedge clk) begin
      if (shadow_we) shadow_q[idx_q] <= bus.rx_byte;
   end

   assign err_fire      = err_now | short_q;
   assign err_fire_code = err_now ? err_now_code : ERR_SHORT;

   always_ff @(posedge clk) begin
      if (rst) begin
         buttons_q    <= '0;
         rjoy_x_q     <= JOY_CENTER;
         rjoy_y_q     <= JOY_CENTER;
         ljoy_x_q     <= JOY_CENTER;
         ljoy_y_q     <= JOY_CENTER;
         pad_id_q     <= PSX_ID_NONE;
         frame_done_q <= 1'b0;
         frame_err_q  <= 1'b0;
         err_code_q   <= ERR_HDR;
         miss_q       <= '0;
         connected_q  <= 1'b0;
      end else begin
         frame_done_q <= commit_q;
         frame_err_q  <= err_fire;
         if (commit_q) begin
            buttons_q   <= ~{shadow_q[1], shadow_q[0]};
            pad_id_q    <= id_q;
            miss_q      <= '0;
            connected_q <= 1'b1;
            if (len_q >= IDX_W'(JOY_BYTES)) begin
               rjoy_x_q <= shadow_q[2];
               rjoy_y_q <= shadow_q[3];
               ljoy_x_q <= shadow_q[4];
               ljoy_y_q <= shadow_q[5];
            end else begin
               rjoy_x_q <= JOY_CENTER;
               rjoy_y_q <= JOY_CENTER;
               ljoy_x_q <= JOY_CENTER;
               ljoy_y_q <= JOY_CENTER;
            end
         end
         if (err_fire) begin
            err_code_q <= err_fire_code;
            if (miss_q < MISS_W'(MISS_LIMIT)) begin
               miss_q <= miss_q + MISS_W'(1);
               if (miss_q + MISS_W'(1) == MISS_W'(MISS_LIMIT)) connected_q <= 1'b0;
            end
         end
      end
   end

   assign bus.buttons    = buttons_q;
   assign bus.rjoy_x     = rjoy_x_q;
   assign bus.rjoy_y     = rjoy_y_q;
   assign bus.ljoy_x     = ljoy_x_q;
   assign bus.ljoy_y     = ljoy_y_q;
   assign bus.pad_id     = pad_id_q;
   assign bus.frame_done = frame_done_q;
   assign bus.frame_err  = frame_err_q;
   assign bus.err_code   = err_code_q;
   assign bus.connected  = connected_q;

endmodule
